// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues word fetches to instruction
//   memory over a req/ack handshake and captures the returned word in a
//   one-entry instruction register that decode drains through valid/ready.
//   Execute can redirect the PC at any time; the fetched word is flushed.
//   A misaligned redirect target halts fetching until an aligned redirect.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   imem_req / imem_addr       fetch request and address (address = pc)
//   imem_ack / imem_rdata      memory response, honoured only while imem_req
//   instr / instr_pc           instruction register and its fetch address
//   instr_valid / instr_ready  handshake towards decode
//   redirect / redirect_pc     PC redirect from execute (highest priority)
//   fetch_err                  misaligned redirect target, fetching halted
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | just out of reset, first fetch starts on the next edge
// FETCH | request outstanding for pc, waiting on imem_ack
// FULL  | instruction register holds an unconsumed instruction
// ERR   | misaligned redirect seen, waiting for an aligned redirect
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        // Redirect wins over ack and over a decode transfer: any word returned
        // in the same cycle is dropped and the held instruction is flushed.
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] != 2'b00) ? ERR : FETCH;
        end else begin
            unique case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = FULL;
                    end
                end
                FULL: begin
                    if (instr_ready) begin
                        state_d = FETCH;
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // All outputs come from registers only; no input reaches an output
    // combinationally.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == FULL);
    assign fetch_err   = (state_q == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_err;

    int n_cmp = 0;
    int n_mis = 0;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // Reference model: a fetch stage that has "started", may hold one
    // instruction, or be halted by an error.
    bit          m_started;
    bit          m_holding;
    bit          m_halted;
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          bad_seen;   // 0xDEADBEEF must never reach instr

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_holding = 0;
        m_halted  = 0;
        m_pc      = RST_PC;
        m_instr   = NOP;
        m_ipc     = RST_PC;
    endtask

    task automatic model_step();
        if (redirect) begin
            m_pc      = redirect_pc;
            m_holding = 0;
            m_halted  = (redirect_pc % 4) != 0;
            m_started = 1;
        end else if (m_halted) begin
        end else if (!m_started) begin
            m_started = 1;
        end else if (!m_holding) begin
            if (imem_ack) begin
                m_instr   = imem_rdata;
                m_ipc     = m_pc;
                m_pc      = m_pc + 4;
                m_holding = 1;
            end
        end else if (instr_ready) begin
            m_holding = 0;
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = m_started && !m_holding && !m_halted;
        chk("req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("addr", imem_addr, m_pc);
        chk("valid", {31'b0, instr_valid}, {31'b0, m_holding});
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("err", {31'b0, fetch_err}, {31'b0, m_halted});
        if (instr == 32'hDEAD_BEEF) bad_seen = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic ack, input logic [31:0] rd, input logic rdy,
                          input logic rdir, input logic [31:0] rpc);
        imem_ack    = ack;
        imem_rdata  = rd;
        instr_ready = rdy;
        redirect    = rdir;
        redirect_pc = rpc;
    endtask

    initial begin
        bad_seen = 0;
        model_reset();
        #12;
        check_all();                               // reset values
        chk("rst_instr", instr, NOP);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: first fetch at RESET_PC, zero-wait memory
        set_in(1, 32'h00A0_0093, 0, 0, 0);
        tick();                                    // edge 1 -> requesting
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h100);
        tick();
        chk("t1_instr", instr, 32'h00A0_0093);
        chk("t1_ipc", instr_pc, 32'h100);

        // 2: backpressure
        for (int i = 0; i < 5; i++) begin
            set_in(1, $urandom, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 1, 0, 0);
        tick();
        chk("t2_addr", imem_addr, 32'h104);
        chk("t2_valid", {31'b0, instr_valid}, 32'd0);

        // 3: redirect together with ack
        set_in(1, 32'hDEAD_BEEF, 0, 1, 32'h200);
        tick();
        chk("t3_instr", instr, 32'h00A0_0093);
        chk("t3_addr", imem_addr, 32'h200);
        set_in(0, 32'hDEAD_BEEF, 0, 0, 0);
        tick();

        // 4: misaligned then aligned redirect
        set_in(0, 0, 0, 1, 32'h202);
        tick();
        chk("t4_err", {31'b0, fetch_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_in(1, $urandom, 1, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 1, 32'h204);
        tick();
        chk("t4_addr", imem_addr, 32'h204);

        // 5: PC wrap
        set_in(0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        set_in(1, 32'h1234_5678, 0, 0, 0);
        tick();
        chk("t5_ipc", instr_pc, 32'hFFFF_FFFC);
        set_in(0, 0, 1, 0, 0);
        tick();
        chk("t5_addr", imem_addr, 32'h0);

        // 6: async reset while waiting on ack
        set_in(0, 0, 0, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t6_instr", instr, NOP);
        set_in(1, 32'hCAFE_0001, 1, 0, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        chk("t6_addr", imem_addr, RST_PC);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            int r;
            r = $urandom_range(0, 99);
            rpc = {$urandom_range(0, 255), 2'b00} + 32'h1000;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8 + {28'b0, rpc[3:0] & 4'h4};
            set_in($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1),
                   r < 8, rpc);
            tick();
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        chk("no_deadbeef", {31'b0, bad_seen}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
